// File: rtl/evm_multi_ballot.sv
// Multi-candidate voting machine: per-button debounce, officer-armed single ballot,
// saturating counters and a sequential winner/tie scan in result mode.
module evm_multi_ballot #(
    parameter int NUM_CAND = 8,
    parameter int CNT_W    = 8,
    parameter int DEBOUNCE = 10,
    parameter int ACK_HOLD = 10,
    parameter int IDX_W    = $clog2(NUM_CAND)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   mode,
    input  logic                   ballot_enable,
    input  logic [NUM_CAND-1:0]    button,
    output logic [CNT_W-1:0]       led,
    output logic                   armed,
    output logic                   vote_ack,
    output logic                   vote_reject,
    output logic [CNT_W+IDX_W-1:0] total_votes,
    output logic [IDX_W-1:0]       winner_idx,
    output logic                   winner_valid,
    output logic                   tie
);
    localparam int DEB_W = $clog2(DEBOUNCE + 1);
    localparam int ACK_W = $clog2(ACK_HOLD + 1);
    localparam int TOT_W = CNT_W + IDX_W;
    localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CAND - 1);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACK, S_RESULT} state_e;

    state_e             state_q, state_d;
    logic               be_q;
    logic [DEB_W-1:0]   deb_q [NUM_CAND];
    logic [DEB_W-1:0]   deb_d [NUM_CAND];
    logic [CNT_W-1:0]   cnt_q [NUM_CAND];
    logic [CNT_W-1:0]   cnt_d [NUM_CAND];
    logic [TOT_W-1:0]   total_q, total_d;
    logic [CNT_W-1:0]   led_q, led_d;
    logic               ack_q, ack_d, rej_q, rej_d;
    logic [ACK_W-1:0]   ack_cnt_q, ack_cnt_d;
    logic               scan_act_q, scan_act_d;
    logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
    logic [CNT_W-1:0]   scan_max_q, scan_max_d;
    logic [IDX_W-1:0]   scan_best_q, scan_best_d;
    logic               scan_tie_q, scan_tie_d;
    logic [IDX_W-1:0]   win_idx_q, win_idx_d;
    logic               win_valid_q, win_valid_d;
    logic               tie_q, tie_d;

    logic [NUM_CAND-1:0] valid;
    logic                any_valid, multi_valid, one_hot;
    logic [IDX_W-1:0]    sel_idx;
    logic                be_rise, scan_start;
    logic [CNT_W-1:0]    cur_cnt, nmax;
    logic [IDX_W-1:0]    nbest;
    logic                ntie;

    // A channel pulses only on the cycle its counter reaches DEBOUNCE; it then parks until release.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            deb_d[i] = deb_q[i];
            valid[i] = button[i] && (deb_q[i] == DEB_LAST);
            if (!button[i]) begin
                deb_d[i] = '0;
            end else if (deb_q[i] != DEB_MAX) begin
                deb_d[i] = deb_q[i] + 1'b1;
            end
            if (valid[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
        any_valid   = |valid;
        multi_valid = |(valid & (valid - NUM_CAND'(1)));
        one_hot     = any_valid && !multi_valid;
    end

    assign be_rise = ballot_enable && !be_q;

    always_comb begin
        state_d     = state_q;
        led_d       = led_q;
        ack_d       = 1'b0;
        rej_d       = 1'b0;
        ack_cnt_d   = ack_cnt_q;
        cnt_d       = cnt_q;
        total_d     = total_q;
        scan_start  = 1'b0;
        scan_act_d  = scan_act_q;
        scan_idx_d  = scan_idx_q;
        scan_max_d  = scan_max_q;
        scan_best_d = scan_best_q;
        scan_tie_d  = scan_tie_q;
        win_idx_d   = win_idx_q;
        win_valid_d = win_valid_q;
        tie_d       = tie_q;
        cur_cnt     = cnt_q[scan_idx_q];
        nmax        = scan_max_q;
        nbest       = scan_best_q;
        ntie        = scan_tie_q;

        case (state_q)
            S_IDLE: begin
                led_d = '0;
                rej_d = any_valid;
                if (mode) begin
                    state_d    = S_RESULT;
                    scan_start = 1'b1;
                end else if (be_rise) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (mode) begin
                    state_d    = S_RESULT;
                    scan_start = 1'b1;
                    rej_d      = any_valid;
                end else if (one_hot) begin
                    ack_d     = 1'b1;
                    state_d   = S_ACK;
                    led_d     = '1;
                    ack_cnt_d = '0;
                    if (!(&cnt_q[sel_idx])) begin
                        cnt_d[sel_idx] = cnt_q[sel_idx] + 1'b1;
                    end
                    if (!(&total_q)) begin
                        total_d = total_q + 1'b1;
                    end
                end else if (multi_valid) begin
                    rej_d = 1'b1;
                end
            end
            S_ACK: begin
                rej_d = any_valid;
                if (ack_cnt_q == ACK_LAST) begin
                    state_d = S_IDLE;
                    led_d   = '0;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            S_RESULT: begin
                if (!mode) begin
                    state_d = S_IDLE;
                    led_d   = '0;
                end else if (any_valid) begin
                    scan_start = 1'b1;
                    if (one_hot) begin
                        led_d = cnt_q[sel_idx];
                    end else begin
                        rej_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Scan visits one candidate per cycle; results are published together on the last index.
        if (state_d != S_RESULT) begin
            scan_act_d  = 1'b0;
            win_valid_d = 1'b0;
        end else if (scan_start) begin
            scan_act_d  = 1'b1;
            scan_idx_d  = '0;
            win_valid_d = 1'b0;
        end else if (scan_act_q) begin
            if (scan_idx_q == '0) begin
                nmax  = cur_cnt;
                nbest = '0;
                ntie  = 1'b0;
            end else if (cur_cnt > scan_max_q) begin
                nmax  = cur_cnt;
                nbest = scan_idx_q;
                ntie  = 1'b0;
            end else if (cur_cnt == scan_max_q) begin
                ntie = 1'b1;
            end
            scan_max_d  = nmax;
            scan_best_d = nbest;
            scan_tie_d  = ntie;
            if (scan_idx_q == IDX_LAST) begin
                scan_act_d  = 1'b0;
                win_idx_d   = nbest;
                tie_d       = ntie;
                win_valid_d = 1'b1;
            end else begin
                scan_idx_d = scan_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            be_q        <= 1'b0;
            total_q     <= '0;
            led_q       <= '0;
            ack_q       <= 1'b0;
            rej_q       <= 1'b0;
            ack_cnt_q   <= '0;
            scan_act_q  <= 1'b0;
            scan_idx_q  <= '0;
            scan_max_q  <= '0;
            scan_best_q <= '0;
            scan_tie_q  <= 1'b0;
            win_idx_q   <= '0;
            win_valid_q <= 1'b0;
            tie_q       <= 1'b0;
            for (int i = 0; i < NUM_CAND; i++) begin
                deb_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            be_q        <= ballot_enable;
            total_q     <= total_d;
            led_q       <= led_d;
            ack_q       <= ack_d;
            rej_q       <= rej_d;
            ack_cnt_q   <= ack_cnt_d;
            scan_act_q  <= scan_act_d;
            scan_idx_q  <= scan_idx_d;
            scan_max_q  <= scan_max_d;
            scan_best_q <= scan_best_d;
            scan_tie_q  <= scan_tie_d;
            win_idx_q   <= win_idx_d;
            win_valid_q <= win_valid_d;
            tie_q       <= tie_d;
            for (int i = 0; i < NUM_CAND; i++) begin
                deb_q[i] <= deb_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign led          = led_q;
    assign armed        = (state_q == S_ARMED);
    assign vote_ack     = ack_q;
    assign vote_reject  = rej_q;
    assign total_votes  = total_q;
    assign winner_idx   = win_idx_q;
    assign winner_valid = win_valid_q;
    assign tie          = tie_q;
endmodule

// File: tb/tb_evm_multi_ballot.sv
// Bench for evm_multi_ballot: directed ballots; ack/reject events are matched against
// an expected queue (kind, total_votes, cycle), other outputs checked inline.
module tb_evm_multi_ballot;
    localparam int N   = 8;
    localparam int CW  = 8;
    localparam int DEB = 10;
    localparam int IW  = 3;
    localparam int TW  = CW + IW;
    localparam int W   = 2 + TW + 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          mode = 1'b0;
    logic          ballot_enable = 1'b0;
    logic [N-1:0]  button = '0;
    logic [CW-1:0] led;
    logic          armed, vote_ack, vote_reject, winner_valid, tie;
    logic [TW-1:0] total_votes;
    logic [IW-1:0] winner_idx;

    logic [W-1:0] exp_q[$];
    int total_cnt = 0;
    int bad_cnt = 0;
    int cyc = 0;
    int exp_total = 0;

    evm_multi_ballot dut (
        .clock(clock), .reset(reset), .mode(mode), .ballot_enable(ballot_enable),
        .button(button), .led(led), .armed(armed), .vote_ack(vote_ack),
        .vote_reject(vote_reject), .total_votes(total_votes), .winner_idx(winner_idx),
        .winner_valid(winner_valid), .tie(tie)
    );

    // clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act != exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every ack/reject pulse must match the oldest expected event
    always @(negedge clock) begin
        logic [W-1:0] act, e;
        if (reset && (vote_ack || vote_reject)) begin
            act = {vote_ack, vote_reject, total_votes, cyc};
            total_cnt++;
            if (exp_q.size() == 0) begin
                bad_cnt++;
                $display("FAIL event: got ack=%0b rej=%0b total=%0d cyc=%0d with none expected",
                         vote_ack, vote_reject, total_votes, cyc);
            end else begin
                e = exp_q.pop_front();
                if (act != e) begin
                    bad_cnt++;
                    $display("FAIL event: got ack=%0b rej=%0b total=%0d cyc=%0d expected ack=%0b rej=%0b total=%0d cyc=%0d",
                             act[W-1], act[W-2], act[W-3:32], act[31:0],
                             e[W-1], e[W-2], e[W-3:32], e[31:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock) reset = 1'b0;
        @(negedge clock) reset = 1'b1;
        exp_total = 0;
    endtask

    task automatic arm();
        @(negedge clock) ballot_enable = 1'b1;
        @(negedge clock) ballot_enable = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] kind, input int tot, input int at);
        logic [TW-1:0] t;
        t = TW'(tot);
        exp_q.push_back({kind, t, at});
    endtask

    // kind: 2'b10 ack, 2'b01 reject, 2'b00 no event expected
    task automatic press(input logic [N-1:0] m, input int hold, input logic [1:0] kind, input int tot);
        @(negedge clock);
        button = m;
        if (kind != 2'b00) push_exp(kind, tot, cyc + DEB);
        repeat (hold) @(negedge clock);
        button = '0;
    endtask

    task automatic vote(input int cand);
        logic [N-1:0] m;
        m = '0;
        m[cand] = 1'b1;
        arm();
        exp_total++;
        press(m, 11, 2'b10, exp_total);
        tick(12);
    endtask

    initial begin
        int c;
        tick(3);
        chk("rst_led", int'(led), 0);
        chk("rst_armed", int'(armed), 0);
        chk("rst_ack", int'(vote_ack), 0);
        chk("rst_rej", int'(vote_reject), 0);
        chk("rst_total", int'(total_votes), 0);
        chk("rst_widx", int'(winner_idx), 0);
        chk("rst_wvalid", int'(winner_valid), 0);
        chk("rst_tie", int'(tie), 0);
        @(negedge clock) reset = 1'b1;
        tick(2);

        // armed vote for candidate 2: led all-ones for 10 cycles, armed drops with the ack
        arm();
        @(negedge clock);
        button = 8'h04;
        c = cyc;
        exp_total = 1;
        push_exp(2'b10, 1, c + DEB);
        for (int off = 1; off <= 24; off++) begin
            @(negedge clock);
            if (off == 12) button = '0;
            chk("led_ack", int'(led), (off >= 10 && off <= 19) ? 255 : 0);
            chk("armed_vote", int'(armed), (off <= 9) ? 1 : 0);
        end

        // no re-arm: refused
        press(8'h04, 12, 2'b01, 1);
        tick(3);

        // ambiguous press refused while staying armed, then a clean vote
        arm();
        press(8'h22, 12, 2'b01, 1);
        tick(1);
        chk("armed_after_multi", int'(armed), 1);
        exp_total = 2;
        press(8'h20, 12, 2'b10, 2);
        tick(12);

        // result mode cancels an arm and ignores ballot_enable
        arm();
        @(negedge clock) mode = 1'b1;
        @(negedge clock);
        chk("armed_cancel", int'(armed), 0);
        ballot_enable = 1'b1;
        tick(2);
        chk("armed_in_result", int'(armed), 0);
        ballot_enable = 1'b0;
        mode = 1'b0;
        tick(2);
        press(8'h01, 12, 2'b01, 2);
        tick(3);

        // saturation of candidate 0
        do_reset();
        tick(2);
        for (int i = 0; i < 256; i++) vote(0);
        @(negedge clock) mode = 1'b1;
        tick(2);
        press(8'h01, 12, 2'b00, 0);
        tick(2);
        chk("sat_count0", int'(led), 255);
        chk("sat_total", int'(total_votes), 256);
        @(negedge clock) mode = 1'b0;
        tick(2);
        chk("led_leave_result", int'(led), 0);

        // winner scan: c3=4, c6=4, c7=3, c1=2
        do_reset();
        tick(2);
        for (int i = 0; i < 4; i++) vote(3);
        for (int i = 0; i < 4; i++) vote(6);
        for (int i = 0; i < 3; i++) vote(7);
        for (int i = 0; i < 2; i++) vote(1);
        @(negedge clock) mode = 1'b1;
        for (int off = 1; off <= 9; off++) begin
            @(negedge clock);
            chk("wvalid_rise", int'(winner_valid), (off >= 9) ? 1 : 0);
        end
        chk("widx_tie", int'(winner_idx), 3);
        chk("tie_set", int'(tie), 1);

        @(negedge clock);
        button = 8'h40;
        for (int off = 1; off <= 20; off++) begin
            @(negedge clock);
            if (off == 12) button = '0;
            chk("led_count6", int'(led), (off >= 10) ? 4 : 0);
            chk("wvalid_rescan", int'(winner_valid), (off >= 10 && off <= 17) ? 0 : 1);
        end
        chk("widx_rescan", int'(winner_idx), 3);
        chk("tie_rescan", int'(tie), 1);

        press(8'h48, 12, 2'b01, 13);
        tick(1);
        chk("led_hold_multi", int'(led), 4);
        tick(10);
        chk("wvalid_after_multi", int'(winner_valid), 1);
        @(negedge clock) mode = 1'b0;
        @(negedge clock);
        chk("led_idle", int'(led), 0);
        chk("wvalid_idle", int'(winner_valid), 0);
        tick(2);

        // break the tie: c3=5 becomes sole maximum
        vote(3);
        @(negedge clock) mode = 1'b1;
        tick(10);
        chk("wvalid_single", int'(winner_valid), 1);
        chk("widx_single", int'(winner_idx), 3);
        chk("tie_clear", int'(tie), 0);
        @(negedge clock) mode = 1'b0;
        tick(2);

        // reset mid-debounce while armed
        arm();
        @(negedge clock) button = 8'h10;
        tick(5);
        @(negedge clock) reset = 1'b0;
        #1;
        chk("midrst_armed", int'(armed), 0);
        chk("midrst_led", int'(led), 0);
        chk("midrst_total", int'(total_votes), 0);
        chk("midrst_ack", int'(vote_ack), 0);
        chk("midrst_wvalid", int'(winner_valid), 0);
        chk("midrst_tie", int'(tie), 0);
        @(negedge clock) reset = 1'b1;
        exp_total = 0;
        push_exp(2'b01, 0, cyc + DEB);
        tick(12);
        button = '0;
        tick(3);

        // all counts zero: index 0 with a tie
        @(negedge clock) mode = 1'b1;
        tick(10);
        chk("zero_wvalid", int'(winner_valid), 1);
        chk("zero_widx", int'(winner_idx), 0);
        chk("zero_tie", int'(tie), 1);
        @(negedge clock) mode = 1'b0;
        tick(5);

        chk("pending_events", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule

// File: doc/evm_multi_ballot.md
Name: evm_multi_ballot

Overview:
Parametrised successor to the 4-candidate voting machine. Supports NUM_CAND candidates with per-button debounce, saturating vote counters, and an officer-armed ballot: exactly one vote per arm. Ambiguous multi-button presses are rejected. Result mode adds a sequential winner/tie scan alongside per-candidate count display. This is the top-level voting block; it drives the LED bank and status outputs.

Parameters:
NUM_CAND, 8, number of candidate buttons/counters (2..16)
CNT_W, 8, width of each vote counter and of led
DEBOUNCE, 10, consecutive high cycles before a press is valid (>=2)
ACK_HOLD, 10, cycles led is held at all-ones after an accepted vote
IDX_W, $clog2(NUM_CAND), width of candidate index outputs

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
mode  in  1  0 = voting, 1 = result
ballot_enable  in  1  officer arm request, level; rising edge arms one ballot
button  in  NUM_CAND  raw candidate buttons, bit i = candidate i
led  out  CNT_W  display: ack pattern in voting, selected count in result
armed  out  1  high while a ballot is armed and awaiting a press
vote_ack  out  1  one-cycle pulse when a vote is counted
vote_reject  out  1  one-cycle pulse when a press is refused
total_votes  out  CNT_W+IDX_W  sum of all accepted votes, saturating
winner_idx  out  IDX_W  lowest index holding the max count
winner_valid  out  1  high when the scan is complete and current
tie  out  1  max count is held by more than one candidate

Behaviour:
- Reset (reset=0, async): all counters, debounce state, led, total_votes and winner_idx are 0; armed, vote_ack, vote_reject, winner_valid and tie are 0; FSM enters IDLE.
- Debounce, per channel: deb_cnt increments while button[i]=1 and deb_cnt<DEBOUNCE, and clears when button[i]=0. valid[i] pulses for one cycle on the cycle deb_cnt reaches DEBOUNCE. A held button yields one pulse only, and must be released before it can pulse again.
- FSM states: IDLE, ARMED, ACK, RESULT.
- IDLE: led=0, armed=0. A rising edge of ballot_enable with mode=0 moves to ARMED. Any valid pulse here gives vote_reject and counts nothing.
- ARMED: armed=1.
  - Exactly one valid bit set: count[i] increments, saturating at 2^CNT_W-1. total_votes increments, saturating. vote_ack pulses the same cycle. The FSM moves to ACK.
  - Two or more valid bits set in the same cycle: vote_reject pulses, nothing is counted, the FSM stays in ARMED.
  - A saturated count[i] still returns vote_ack, the FSM still moves to ACK, and the count holds.
- ACK: led=all-ones for ACK_HOLD cycles, then led=0 and the FSM returns to IDLE; re-arming is required. Valid pulses during ACK give vote_reject. A mode change is deferred until ACK completes.
- mode=1 from IDLE or ARMED: go to RESULT next cycle and clear the arm; a pending ballot is cancelled.
- mode=0 in RESULT: go to IDLE; led=0.
- RESULT:
  - On entry, and again on every valid pulse, a winner scan starts. winner_valid drops to 0 and the scan visits index 0..NUM_CAND-1, one per cycle.
  - The scan tracks max and the first index reaching it, and sets tie if a later index equals max.
  - winner_valid=1 exactly NUM_CAND+1 cycles after scan start, and stays 1 until the next scan start or until leaving RESULT.
  - All counts 0: winner_idx=0, and tie=1 if NUM_CAND>1.
  - Single valid bit i: led=count[i] next cycle; led holds until another single press. Multiple simultaneous valid bits: led unchanged, vote_reject pulses.
- Counters never change in RESULT. ballot_enable is ignored in RESULT.
- A rising edge of ballot_enable in any state other than IDLE is ignored; no queueing.
- vote_ack and vote_reject are mutually exclusive and are never high for two consecutive cycles from the same press.
- Reset asserted mid-operation (any state, mid-debounce, mid-scan) clears everything immediately; no vote is committed on that edge.

Test Plan:
- Reset, arm, hold button[2] high for 12 cycles -> vote_ack exactly once, DEBOUNCE cycles after press start. count[2]=1, total_votes=1, led=0xFF for 10 cycles then 0, armed=0.
- Without re-arming, press button[2] again for 12 cycles -> vote_reject pulse, count[2] stays 1, total_votes stays 1.
- Arm, then press button[1] and button[5] together for 12 cycles -> one vote_reject, both counts unchanged, armed remains 1. Then press button[5] alone -> count[5]=1, vote_ack.
- Cast 255 votes for candidate 0, then one more -> count[0]=255 held, vote_ack still pulses, total_votes=256.
- With counts c3=4, c6=4, all others below 4, set mode=1 -> winner_valid rises 9 cycles later (NUM_CAND=8) with winner_idx=3 and tie=1. Press button[6] -> led=4, winner_valid drops, then re-rises with the same result.
- Arm, hold button[4] for 5 cycles, assert reset low for 1 cycle -> all outputs 0, FSM in IDLE. Holding button[4] 12 more cycles after release gives vote_reject (not armed) and no count.
